// File: rtl/wb_mcb_pkg.sv
// Shared definitions for the two-port Wishbone to Spartan-6 MCB user-port
// controller: sequencer state encoding, MCB command opcodes and the width
// helper for the read-timeout counter.
package wb_mcb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_CMD  = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam logic [2:0] MCB_INSTR_READ  = 3'b001;

  // Counter must hold TIMEOUT-1; never narrower than one bit.
  function automatic int tmo_cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/arb_rr_2.sv
// Two-way round-robin arbiter (purely combinational).
//   req0_i, req1_i : request from port 0 / port 1
//   last_grant_i   : index of the port granted most recently
//   en_i           : arbitration allowed this cycle
//   grant_o        : index of the winning port (meaningful when valid_o = 1)
//   valid_o        : a grant is being made this cycle
module arb_rr_2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  input  logic en_i,
  output logic grant_o,
  output logic valid_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_o = 1'b0;
    valid_o = 1'b0;
    if (en_i) begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
        // Tie: the port that did not win last time goes first.
        grant_o = ~last_grant_i;
      end else begin
        grant_o = req1_i;
      end
    end
  end

endmodule

// File: rtl/wb_mcb_arb_2.sv
// Shares one 32-bit Spartan-6 MCB user port between two 32-bit Wishbone slave
// ports. Round-robin arbitration, a single one-word transaction in flight.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   wbN_*               : Wishbone slave port N (adr/dat/sel/we/stb/cyc in,
//                         dat_o/ack_o/err_o out, all outputs registered)
//   mcb_cmd_*           : MCB command FIFO (en/instr/bl/byte_addr, full in)
//   mcb_wr_*            : MCB write-data FIFO (en/mask/data, full in)
//   mcb_rd_*            : MCB read-data FIFO (en out, data/empty in)
//   mcb_*_clk           : FIFO clocks, all driven by clk
//   grant_o             : port currently or most recently granted
module wb_mcb_arb_2
  import wb_mcb_pkg::*;
#(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] wb0_adr_i,
  input  logic [31:0] wb0_dat_i,
  output logic [31:0] wb0_dat_o,
  input  logic [3:0]  wb0_sel_i,
  input  logic        wb0_we_i,
  input  logic        wb0_stb_i,
  input  logic        wb0_cyc_i,
  output logic        wb0_ack_o,
  output logic        wb0_err_o,

  input  logic [31:0] wb1_adr_i,
  input  logic [31:0] wb1_dat_i,
  output logic [31:0] wb1_dat_o,
  input  logic [3:0]  wb1_sel_i,
  input  logic        wb1_we_i,
  input  logic        wb1_stb_i,
  input  logic        wb1_cyc_i,
  output logic        wb1_ack_o,
  output logic        wb1_err_o,

  output logic        mcb_cmd_clk,
  output logic        mcb_cmd_en,
  output logic [2:0]  mcb_cmd_instr,
  output logic [5:0]  mcb_cmd_bl,
  output logic [31:0] mcb_cmd_byte_addr,
  input  logic        mcb_cmd_full,

  output logic        mcb_wr_clk,
  output logic        mcb_wr_en,
  output logic [3:0]  mcb_wr_mask,
  output logic [31:0] mcb_wr_data,
  input  logic        mcb_wr_full,

  output logic        mcb_rd_clk,
  output logic        mcb_rd_en,
  input  logic [31:0] mcb_rd_data,
  input  logic        mcb_rd_empty,

  output logic        grant_o
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [3:0]        mask_q, mask_d;
  logic [2:0]        instr_q, instr_d;
  logic              cmd_en_q, cmd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [31:0]       dat0_q, dat0_d, dat1_q, dat1_d;

  logic              req0, req1;
  logic              arb_grant, arb_valid;
  logic [31:0]       g_adr, g_dat;
  logic [3:0]        g_sel;
  logic              g_we;

  // A port is not re-requesting while its own termination is still visible.
  assign req0 = wb0_cyc_i & wb0_stb_i & ~ack0_q & ~err0_q;
  assign req1 = wb1_cyc_i & wb1_stb_i & ~ack1_q & ~err1_q;

  arb_rr_2 u_arb (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (grant_q),
    .en_i         ((state_q == S_IDLE) && mcb_rd_empty),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  assign g_adr = arb_grant ? wb1_adr_i : wb0_adr_i;
  assign g_dat = arb_grant ? wb1_dat_i : wb0_dat_i;
  assign g_sel = arb_grant ? wb1_sel_i : wb0_sel_i;
  assign g_we  = arb_grant ? wb1_we_i  : wb0_we_i;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    mask_d    = mask_q;
    instr_d   = instr_q;
    dat0_d    = dat0_q;
    dat1_d    = dat1_q;
    cmd_en_d  = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mcb_rd_empty) begin
          // Drain a stale word. rd_en is registered, so the FIFO flag still
          // shows the word popped last cycle; skip that cycle to pop only once.
          rd_en_d = ~rd_en_q;
        end else if (arb_valid) begin
          grant_d   = arb_grant;
          addr_d    = {g_adr[31:2], 2'b00};
          wr_data_d = g_dat;
          mask_d    = ~g_sel;
          we_d      = g_we;
          state_d   = g_we ? S_WR_DATA : S_RD_CMD;
        end
      end

      S_WR_DATA: begin
        if (!mcb_wr_full) begin
          wr_en_d = 1'b1;
          state_d = S_WR_CMD;
        end
      end

      S_WR_CMD: begin
        if (!mcb_cmd_full) begin
          cmd_en_d = 1'b1;
          instr_d  = MCB_INSTR_WRITE;
          state_d  = S_DONE;
        end
      end

      S_RD_CMD: begin
        if (!mcb_cmd_full) begin
          cmd_en_d = 1'b1;
          instr_d  = MCB_INSTR_READ;
          cnt_d    = '0;
          tmo_d    = 1'b0;
          state_d  = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (!mcb_rd_empty) begin
          rd_en_d = 1'b1;
          if (grant_q) dat1_d = mcb_rd_data;
          else         dat0_d = mcb_rd_data;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) begin
            if (grant_q) dat1_d = ERR_DATA;
            else         dat0_d = ERR_DATA;
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // A master that dropped cyc has abandoned the cycle: stay silent.
        if (grant_q) begin
          ack1_d = wb1_cyc_i & ~tmo_q;
          err1_d = wb1_cyc_i &  tmo_q;
        end else begin
          ack0_d = wb0_cyc_i & ~tmo_q;
          err0_d = wb0_cyc_i &  tmo_q;
        end
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; the reset is synchronous, so it
  // lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b1;
      we_q      <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      mask_q    <= '0;
      instr_q   <= '0;
      cmd_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      dat0_q    <= '0;
      dat1_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      mask_q    <= mask_d;
      instr_q   <= instr_d;
      cmd_en_q  <= cmd_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      dat0_q    <= dat0_d;
      dat1_q    <= dat1_d;
    end
  end

  assign mcb_cmd_clk       = clk;
  assign mcb_wr_clk        = clk;
  assign mcb_rd_clk        = clk;
  assign mcb_cmd_bl        = 6'd0;
  assign mcb_cmd_en        = cmd_en_q;
  assign mcb_cmd_instr     = instr_q;
  assign mcb_cmd_byte_addr = addr_q;
  assign mcb_wr_en         = wr_en_q;
  assign mcb_wr_mask       = mask_q;
  assign mcb_wr_data       = wr_data_q;
  assign mcb_rd_en         = rd_en_q;
  assign wb0_ack_o         = ack0_q;
  assign wb1_ack_o         = ack1_q;
  assign wb0_err_o         = err0_q;
  assign wb1_err_o         = err1_q;
  assign wb0_dat_o         = dat0_q;
  assign wb1_dat_o         = dat1_q;
  assign grant_o           = grant_q;

endmodule

// File: tb/tb_wb_mcb_arb_2.sv
// Bench for wb_mcb_arb_2: directed Wishbone transactions on both ports, an MCB
// FIFO model with configurable read latency and full flags, and scoreboard
// queues popped by a monitor on every MCB strobe and Wishbone termination.
module tb_wb_mcb_arb_2;

  typedef struct {
    logic        is_cmd;
    logic [2:0]  instr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        grant;
  } mcb_op_t;

  typedef struct {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
    int          cyc;
  } term_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cyc = '0, stb = '0, we = '0;
  logic [31:0] adr [2];
  logic [31:0] dat_w [2];
  logic [3:0]  sel [2];
  logic [31:0] dat0_o, dat1_o;
  logic [1:0]  ack, err;
  logic        mcb_cmd_clk, mcb_wr_clk, mcb_rd_clk;
  logic        mcb_cmd_en, mcb_wr_en, mcb_rd_en;
  logic [2:0]  mcb_cmd_instr;
  logic [5:0]  mcb_cmd_bl;
  logic [31:0] mcb_cmd_byte_addr, mcb_wr_data, mcb_rd_data;
  logic [3:0]  mcb_wr_mask;
  logic        mcb_cmd_full = 1'b0, mcb_wr_full = 1'b0, mcb_rd_empty;
  logic        grant_o;

  // Read FIFO model (first-word-fall-through).
  logic [31:0] fifo [8];
  logic [3:0]  wptr = '0, rptr = '0;
  int          rd_delay = 0;
  logic        auto_reply = 1'b1;
  logic [31:0] reply_word = 32'h0;
  int          inject_cnt = 0, inject_seen = 0;
  logic [31:0] inject_word = 32'h0;

  mcb_op_t exp_mcb [$];
  term_t   exp_t0 [$];
  term_t   exp_t1 [$];
  int      total = 0, bad = 0;
  int      cyc_cnt = 0;
  int      rd_pulses = 0;
  logic    last_cmd_full = 1'b0, last_wr_full = 1'b0;

  assign mcb_rd_empty = (wptr == rptr);
  assign mcb_rd_data  = fifo[rptr[2:0]];

  wb_mcb_arb_2 #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .wb0_adr_i(adr[0]), .wb0_dat_i(dat_w[0]), .wb0_dat_o(dat0_o), .wb0_sel_i(sel[0]),
    .wb0_we_i(we[0]), .wb0_stb_i(stb[0]), .wb0_cyc_i(cyc[0]), .wb0_ack_o(ack[0]), .wb0_err_o(err[0]),
    .wb1_adr_i(adr[1]), .wb1_dat_i(dat_w[1]), .wb1_dat_o(dat1_o), .wb1_sel_i(sel[1]),
    .wb1_we_i(we[1]), .wb1_stb_i(stb[1]), .wb1_cyc_i(cyc[1]), .wb1_ack_o(ack[1]), .wb1_err_o(err[1]),
    .mcb_cmd_clk(mcb_cmd_clk), .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr),
    .mcb_cmd_bl(mcb_cmd_bl), .mcb_cmd_byte_addr(mcb_cmd_byte_addr), .mcb_cmd_full(mcb_cmd_full),
    .mcb_wr_clk(mcb_wr_clk), .mcb_wr_en(mcb_wr_en), .mcb_wr_mask(mcb_wr_mask),
    .mcb_wr_data(mcb_wr_data), .mcb_wr_full(mcb_wr_full),
    .mcb_rd_clk(mcb_rd_clk), .mcb_rd_en(mcb_rd_en), .mcb_rd_data(mcb_rd_data),
    .mcb_rd_empty(mcb_rd_empty), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // MCB side: pops on rd_en, answers a read command three cycles later,
  // and accepts words injected by the stimulus.
  always @(posedge clk) begin
    if (mcb_rd_en === 1'b1) rptr <= rptr + 4'd1;
    if (rd_delay != 0) begin
      rd_delay <= rd_delay - 1;
      if (rd_delay == 1) begin
        fifo[wptr[2:0]] <= reply_word;
        wptr <= wptr + 4'd1;
      end
    end else if (inject_cnt != inject_seen) begin
      fifo[wptr[2:0]] <= inject_word;
      wptr <= wptr + 4'd1;
      inject_seen <= inject_cnt;
    end
    if (mcb_cmd_en === 1'b1 && mcb_cmd_instr == 3'b001 && auto_reply) rd_delay <= 3;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    mcb_op_t op;
    op = '{is_cmd: 1'b0, instr: 3'b000, addr: 32'h0, data: d, mask: m, grant: 1'b0};
    exp_mcb.push_back(op);
  endtask

  task automatic push_cmd(input logic [2:0] ins, input logic [31:0] a, input logic g);
    mcb_op_t op;
    op = '{is_cmd: 1'b1, instr: ins, addr: a, data: 32'h0, mask: 4'h0, grant: g};
    exp_mcb.push_back(op);
  endtask

  // Runs one Wishbone cycle on port p starting now (just after a clock edge)
  // and returns just after the edge on which ack/err became visible.
  task automatic wb_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err, input logic chk_dat,
                        input logic [31:0] exp_dat, input int lat);
    term_t t;
    int n;
    t.is_err  = exp_err;
    t.chk_dat = chk_dat;
    t.dat     = exp_dat;
    t.cyc     = (lat < 0) ? -1 : cyc_cnt + lat;
    if (p == 0) exp_t0.push_back(t);
    else        exp_t1.push_back(t);
    adr[p] = a; dat_w[p] = d; sel[p] = s; we[p] = w;
    cyc[p] = 1'b1; stb[p] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack[p] | err[p]) && n < 200);
    check($sformatf("port%0d_term_in_time", p), n < 200, 1);
    cyc[p] = 1'b0; stb[p] = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_strobes"}, {ack, err, mcb_cmd_en, mcb_wr_en, mcb_rd_en}, 0);
    check({tag, "_instr"},   mcb_cmd_instr, 0);
    check({tag, "_addr"},    mcb_cmd_byte_addr, 0);
    check({tag, "_wr_data"}, mcb_wr_data, 0);
    check({tag, "_mask"},    mcb_wr_mask, 0);
    check({tag, "_dat0"},    dat0_o, 0);
    check({tag, "_dat1"},    dat1_o, 0);
    check({tag, "_grant"},   grant_o, 1);
    check({tag, "_bl"},      mcb_cmd_bl, 0);
  endtask

  // Monitor: compares every strobe/termination against the scoreboard.
  initial forever begin
    mcb_op_t op;
    term_t   t;
    @(negedge clk);
    if (mcb_wr_en === 1'b1) begin
      check("wr_en_while_full", last_wr_full, 0);
      check("wr_en_expected", exp_mcb.size() != 0, 1);
      if (exp_mcb.size() != 0) begin
        op = exp_mcb.pop_front();
        check("wr_op_kind", op.is_cmd, 0);
        check("wr_data", mcb_wr_data, op.data);
        check("wr_mask", mcb_wr_mask, op.mask);
      end
    end
    if (mcb_cmd_en === 1'b1) begin
      check("cmd_en_while_full", last_cmd_full, 0);
      check("cmd_en_expected", exp_mcb.size() != 0, 1);
      if (exp_mcb.size() != 0) begin
        op = exp_mcb.pop_front();
        check("cmd_op_kind", op.is_cmd, 1);
        check("cmd_instr", mcb_cmd_instr, op.instr);
        check("cmd_addr", mcb_cmd_byte_addr, op.addr);
        check("cmd_grant", grant_o, op.grant);
      end
    end
    if (mcb_rd_en === 1'b1) rd_pulses++;
    for (int p = 0; p < 2; p++) begin
      if (ack[p] === 1'b1 || err[p] === 1'b1) begin
        check($sformatf("port%0d_term_expected", p), (p == 0) ? exp_t0.size() != 0 : exp_t1.size() != 0, 1);
        if ((p == 0 && exp_t0.size() != 0) || (p == 1 && exp_t1.size() != 0)) begin
          t = (p == 0) ? exp_t0.pop_front() : exp_t1.pop_front();
          check($sformatf("port%0d_err_vs_ack", p), {ack[p], err[p]}, t.is_err ? 2'b01 : 2'b10);
          if (t.chk_dat) check($sformatf("port%0d_dat_o", p), (p == 0) ? dat0_o : dat1_o, t.dat);
          if (t.cyc >= 0) check($sformatf("port%0d_latency", p), cyc_cnt, t.cyc);
        end
      end
    end
    last_cmd_full = mcb_cmd_full;
    last_wr_full  = mcb_wr_full;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; dat_w[i] = '0; sel[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write on port 0: byte lane 2 only, address low bits dropped.
    push_wr(32'hA1B2C3D4, 4'b1011);
    push_cmd(3'b000, 32'h0000_0100, 1'b0);
    wb_txn(0, 1'b1, 32'h0000_0103, 32'hA1B2C3D4, 4'b0100, 1'b0, 1'b0, 32'h0, 4);
    repeat (3) @(posedge clk); #1;

    // Read on port 1: data returns three cycles after the command.
    reply_word = 32'h12345678;
    push_cmd(3'b001, 32'h0000_2000, 1'b1);
    wb_txn(1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h12345678, 8);
    repeat (3) @(posedge clk); #1;
    check("rd_pulses_after_read", rd_pulses, 1);

    // Both ports write back-to-back; last grant was 1 so port 0 goes first.
    push_wr(32'h0000_1000, 4'h0); push_cmd(3'b000, 32'h10, 1'b0);
    push_wr(32'h0000_2000, 4'h0); push_cmd(3'b000, 32'h20, 1'b1);
    push_wr(32'h0000_1001, 4'h0); push_cmd(3'b000, 32'h14, 1'b0);
    push_wr(32'h0000_2001, 4'h0); push_cmd(3'b000, 32'h24, 1'b1);
    fork
      for (int i = 0; i < 2; i++)
        wb_txn(0, 1'b1, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0, -1);
      for (int i = 0; i < 2; i++)
        wb_txn(1, 1'b1, 32'h20 + 32'(4 * i), 32'h2000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0, -1);
    join
    repeat (3) @(posedge clk); #1;

    // Backpressure: command FIFO full for 10 cycles, then write FIFO for 5.
    push_wr(32'hB0B0_0001, 4'h0); push_cmd(3'b000, 32'h500, 1'b0);
    mcb_cmd_full = 1'b1;
    fork
      wb_txn(0, 1'b1, 32'h500, 32'hB0B0_0001, 4'hF, 1'b0, 1'b0, 32'h0, -1);
      begin repeat (10) @(posedge clk); #1 mcb_cmd_full = 1'b0; end
    join
    repeat (2) @(posedge clk); #1;
    push_wr(32'hB0B0_0002, 4'b0111); push_cmd(3'b000, 32'h504, 1'b0);
    mcb_wr_full = 1'b1;
    fork
      wb_txn(0, 1'b1, 32'h504, 32'hB0B0_0002, 4'b1000, 1'b0, 1'b0, 32'h0, -1);
      begin repeat (5) @(posedge clk); #1 mcb_wr_full = 1'b0; end
    join
    repeat (3) @(posedge clk); #1;

    // Timeout: no read data; err 8 cycles after entering RD_WAIT.
    auto_reply = 1'b0;
    push_cmd(3'b001, 32'h400, 1'b0);
    wb_txn(0, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 1'b1, 32'hDEADBEEF, 10);
    inject_word = 32'hCAFEF00D;
    inject_cnt++;
    repeat (6) @(posedge clk); #1;
    check("rd_pulses_after_drain", rd_pulses, 2);
    check("fifo_drained", mcb_rd_empty, 1);
    auto_reply = 1'b1;

    // Abort: port 0 drops cyc while waiting for read data.
    reply_word = 32'h0BAD_0BAD;
    push_cmd(3'b001, 32'h600, 1'b0);
    adr[0] = 32'h600; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
    repeat (3) @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("rd_pulses_after_abort", rd_pulses, 3);
    push_wr(32'h7777_0001, 4'h0); push_cmd(3'b000, 32'h700, 1'b1);
    wb_txn(1, 1'b1, 32'h700, 32'h7777_0001, 4'hF, 1'b0, 1'b0, 32'h0, 4);
    repeat (3) @(posedge clk); #1;

    // Reset while in WR_CMD: write data was pushed, command never is.
    push_wr(32'h8888_0001, 4'h0);
    adr[1] = 32'h800; dat_w[1] = 32'h8888_0001; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midop_reset");
    rst = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    push_wr(32'h55AA55AA, 4'b1100); push_cmd(3'b000, 32'h300, 1'b0);
    wb_txn(0, 1'b1, 32'h300, 32'h55AA55AA, 4'b0011, 1'b0, 1'b0, 32'h0, 4);

    repeat (5) @(posedge clk); #1;
    check("mcb_ops_outstanding", exp_mcb.size(), 0);
    check("port0_terms_outstanding", exp_t0.size(), 0);
    check("port1_terms_outstanding", exp_t1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
